can_rx_destuff_crc: RTL and testbench

//  Receive-side companion to the CAN CRC-15 generator. Consumes sampled bus bits at bit_tick from the
//  bit-timing unit and strips stuff bits, flagging a stuff error on six equal bits. Feeds destuffed
//  SOF..data bits to a CRC-15 engine, captures the 15 received CRC bits and reports match/mismatch.

---
 rtl/can_rx_destuff_crc_pkg.sv | 21 ++
 rtl/can_rx_destuff_crc_if.sv | 33 +++
 rtl/can_rx_destuff_crc_crc.sv | 45 ++++
 rtl/can_rx_destuff_crc.sv | 169 ++++++++++++++++
 tb/tb_can_rx_destuff_crc.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/can_rx_destuff_crc_pkg.sv
`default_nettype none
// ============================================================================
// can_rx_destuff_crc_pkg -- shared constants and FSM state type
// Rev 1.0
// ============================================================================
package can_rx_destuff_crc_pkg;

  localparam int unsigned         CRC_W     = 15;
  localparam logic [CRC_W-1:0]    CRC_POLY  = 15'h4599;
  localparam int unsigned         STUFF_LEN = 5;
  localparam int unsigned         CRC_CNT_W = 4;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_DATA = 2'd1,
    RX_TAIL = 2'd2,
    RX_DONE = 2'd3
  } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/can_rx_destuff_crc_if.sv
`default_nettype none
// ============================================================================
// can_rx_destuff_crc_if -- sampler/decoder side bundle of the CAN rx destuffer
// Rev 1.0
// ============================================================================
interface can_rx_destuff_crc_if;
  import can_rx_destuff_crc_pkg::*;

  logic             bit_tick;
  logic             rx_bit;
  logic             frame_start;
  logic             crc_field;
  logic             dbit_valid;
  logic             dbit;
  logic             stuff_err;
  logic             crc_done;
  logic             crc_err;
  logic [CRC_W-1:0] crc_calc;
  logic [CRC_W-1:0] crc_rcvd;
  logic             busy;

  modport master (
    output bit_tick, rx_bit, frame_start, crc_field,
    input  dbit_valid, dbit, stuff_err, crc_done, crc_err, crc_calc, crc_rcvd, busy
  );

  modport slave (
    input  bit_tick, rx_bit, frame_start, crc_field,
    output dbit_valid, dbit, stuff_err, crc_done, crc_err, crc_calc, crc_rcvd, busy
  );

endinterface
`default_nettype wire

// File: rtl/can_rx_destuff_crc_crc.sv
`default_nettype none
// ============================================================================
// can_rx_destuff_crc_crc -- serial CAN CRC-15 engine, one bit per enabled strobe
// Rev 1.0
// ============================================================================
module can_rx_destuff_crc_crc
  import can_rx_destuff_crc_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY = can_rx_destuff_crc_pkg::CRC_POLY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             crc_reset_i,
  input  logic             bit_tick_i,
  input  logic             crc_enable_i,
  input  logic             bit_i,
  output logic [CRC_W-1:0] crc_o
);

  logic [CRC_W-1:0] crc_q;
  logic [CRC_W-1:0] crc_d;
  logic             w_nxt;

  always_comb begin
    w_nxt = bit_i ^ crc_q[CRC_W-1];
    crc_d = crc_q;
    if (crc_reset_i) begin
      crc_d = '0;
    end else if (bit_tick_i && crc_enable_i) begin
      crc_d = {crc_q[CRC_W-2:0], 1'b0} ^ (w_nxt ? POLY : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule
`default_nettype wire

// File: rtl/can_rx_destuff_crc.sv
`default_nettype none
// ============================================================================
// can_rx_destuff_crc -- CAN receive bit destuffer with CRC-15 capture and check
// Rev 1.0
// ============================================================================
module can_rx_destuff_crc
  import can_rx_destuff_crc_pkg::*;
#(
  parameter int unsigned      STUFF_LEN = can_rx_destuff_crc_pkg::STUFF_LEN,
  parameter logic [CRC_W-1:0] CRC_POLY  = can_rx_destuff_crc_pkg::CRC_POLY
) (
  input  logic                clk,
  input  logic                rst,
  can_rx_destuff_crc_if.slave bus
);

  localparam int unsigned          RUN_W    = $clog2(STUFF_LEN + 1);
  localparam logic [RUN_W-1:0]     RUN_MAX  = RUN_W'(STUFF_LEN);
  localparam logic [RUN_W-1:0]     RUN_ONE  = RUN_W'(1);
  localparam logic [CRC_CNT_W-1:0] CNT_LAST = CRC_CNT_W'(CRC_W - 1);
  localparam logic [CRC_CNT_W-1:0] CNT_ONE  = CRC_CNT_W'(1);

  rx_state_e            state_q, state_d;
  logic [RUN_W-1:0]     run_q, run_d;
  logic                 last_q, last_d;
  logic [CRC_W-1:0]     rcvd_q, rcvd_d;
  logic [CRC_CNT_W-1:0] cnt_q, cnt_d;
  logic                 crc_err_q, crc_err_d;
  logic                 dbit_q;
  logic                 dbit_valid_q;
  logic                 stuff_err_q;
  logic                 crc_done_q;

  logic                 w_tick;
  logic                 w_at_limit;
  logic                 w_stuff_bit;
  logic                 w_stuff_err;
  logic                 w_data_bit;
  logic                 w_crc_bit;
  logic                 w_last_crc;
  logic                 w_done_pulse;
  logic                 w_busy;
  logic [CRC_W-1:0]     w_crc_calc;

  // frame_start swallows any tick in the same clock
  assign w_tick      = bus.bit_tick && !bus.frame_start &&
                       ((state_q == RX_DATA) || (state_q == RX_TAIL));
  assign w_at_limit  = (run_q == RUN_MAX);
  assign w_stuff_bit = w_tick && w_at_limit && (bus.rx_bit != last_q);
  assign w_stuff_err = w_tick && w_at_limit && (bus.rx_bit == last_q);
  assign w_data_bit  = w_tick && !w_at_limit && (state_q == RX_DATA);
  assign w_crc_bit   = w_data_bit && bus.crc_field;
  assign w_last_crc  = w_crc_bit && (cnt_q == CNT_LAST);

  can_rx_destuff_crc_crc #(
    .POLY         (CRC_POLY)
  ) u_crc (
    .clk          (clk),
    .rst          (rst),
    .crc_reset_i  (bus.frame_start),
    .bit_tick_i   (w_data_bit),
    .crc_enable_i (~bus.crc_field),
    .bit_i        (bus.rx_bit),
    .crc_o        (w_crc_calc)
  );

  // Run tracking: stuff bits seed the next run at length one
  always_comb begin
    run_d  = run_q;
    last_d = last_q;
    rcvd_d = rcvd_q;
    cnt_d  = cnt_q;
    if (bus.frame_start) begin
      run_d  = '0;
      rcvd_d = '0;
      cnt_d  = '0;
    end else if (w_stuff_bit) begin
      run_d  = RUN_ONE;
      last_d = bus.rx_bit;
    end else if (w_data_bit) begin
      run_d  = ((bus.rx_bit == last_q) && (run_q != '0)) ? run_q + RUN_ONE : RUN_ONE;
      last_d = bus.rx_bit;
      if (w_crc_bit) begin
        rcvd_d = {rcvd_q[CRC_W-2:0], bus.rx_bit};
        cnt_d  = cnt_q + CNT_ONE;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.frame_start) begin
      state_d = RX_DATA;
    end else begin
      case (state_q)
        RX_IDLE: state_d = RX_IDLE;
        RX_DATA: begin
          if (w_stuff_err) begin
            state_d = RX_IDLE;
          end else if (w_last_crc) begin
            state_d = (run_d == RUN_MAX) ? RX_TAIL : RX_DONE;
          end
        end
        RX_TAIL: begin
          if (w_stuff_err) begin
            state_d = RX_IDLE;
          end else if (w_tick) begin
            state_d = RX_DONE;
          end
        end
        RX_DONE: state_d = RX_IDLE;
        default: state_d = RX_IDLE;
      endcase
    end
  end

  always_comb begin
    w_done_pulse = (state_q == RX_DONE) && !bus.frame_start;
    w_busy       = (state_q != RX_IDLE);
  end

  always_comb begin
    crc_err_d = crc_err_q;
    if (bus.frame_start) begin
      crc_err_d = 1'b0;
    end else if (w_done_pulse) begin
      crc_err_d = (rcvd_q != w_crc_calc);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RX_IDLE;
      run_q        <= '0;
      last_q       <= 1'b0;
      rcvd_q       <= '0;
      cnt_q        <= '0;
      crc_err_q    <= 1'b0;
      dbit_q       <= 1'b0;
      dbit_valid_q <= 1'b0;
      stuff_err_q  <= 1'b0;
      crc_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      last_q       <= last_d;
      rcvd_q       <= rcvd_d;
      cnt_q        <= cnt_d;
      crc_err_q    <= crc_err_d;
      dbit_valid_q <= w_data_bit;
      stuff_err_q  <= w_stuff_err;
      crc_done_q   <= w_done_pulse;
      if (w_data_bit) begin
        dbit_q <= bus.rx_bit;
      end
    end
  end

  assign bus.dbit_valid = dbit_valid_q;
  assign bus.dbit       = dbit_q;
  assign bus.stuff_err  = stuff_err_q;
  assign bus.crc_done   = crc_done_q;
  assign bus.crc_err    = crc_err_q;
  assign bus.crc_calc   = w_crc_calc;
  assign bus.crc_rcvd   = rcvd_q;
  assign bus.busy       = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_can_rx_destuff_crc.sv
`default_nettype none
// ============================================================================
// tb_can_rx_destuff_crc -- randomized frames against a transmitter-side model
// Rev 1.0
// ============================================================================
module tb_can_rx_destuff_crc;
  import can_rx_destuff_crc_pkg::*;

  localparam logic [1:0] K_DBIT  = 2'd0;
  localparam logic [1:0] K_STUFF = 2'd1;
  localparam logic [1:0] K_DONE  = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic        b;
    logic [14:0] calc;
    logic [14:0] rcvd;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  exp_t exp_q[$];
  bit   d_q[$];
  bit   tx_bit[$];
  bit   tx_cf[$];
  bit   tx_st[$];
  int   tx_run;
  bit   tx_last;

  can_rx_destuff_crc_if bus ();

  can_rx_destuff_crc dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // CRC as the remainder of M(x)*x^15 divided by the generator polynomial
  function automatic logic [14:0] crc_div(input int n);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v = {v[126:0], d_q[i]};
    v = v << 15;
    for (int i = n + 14; i >= 15; i--)
      if (v[i]) v[i -: 16] = v[i -: 16] ^ {1'b1, CRC_POLY};
    return v[14:0];
  endfunction

  task automatic push_exp(input logic [1:0] k, input logic b, input logic [14:0] calc,
                          input logic [14:0] rcvd, input logic err);
    exp_t e;
    e.kind = k; e.b = b; e.calc = calc; e.rcvd = rcvd; e.err = err;
    exp_q.push_back(e);
  endtask

  // transmitter-side stuffing: complement after STUFF_LEN equal bits
  task automatic put_tx(input bit b, input bit cf);
    if (tx_run == int'(STUFF_LEN)) begin
      tx_bit.push_back(!tx_last); tx_cf.push_back(cf); tx_st.push_back(1'b1);
      tx_last = !tx_last;
      tx_run  = 1;
    end
    if (tx_run > 0 && b == tx_last) tx_run++;
    else tx_run = 1;
    tx_last = b;
    tx_bit.push_back(b); tx_cf.push_back(cf); tx_st.push_back(1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick(input bit b, input bit cf);
    @(posedge clk); #1;
    bus.bit_tick = 1'b1; bus.rx_bit = b; bus.crc_field = cf;
    @(posedge clk); #1;
    bus.bit_tick = 1'b0;
  endtask

  task automatic start_frame(input bit with_tick);
    @(posedge clk); #1;
    bus.frame_start = 1'b1; bus.bit_tick = with_tick; bus.rx_bit = 1'b1;
    @(posedge clk); #1;
    bus.frame_start = 1'b0; bus.bit_tick = 1'b0;
  endtask

  // inject: -1 none, -2 last stuff bit, k>=0 k-th stuff bit forced equal to its run
  task automatic run_frame(input logic [14:0] crc_val, input int inject, input bit ft_tick);
    int n, inj, nst, last_j, nd;
    logic [14:0] calc;
    n = d_q.size();
    tx_bit.delete(); tx_cf.delete(); tx_st.delete();
    tx_run = 0; tx_last = 1'b0;
    for (int i = 0; i < n; i++) put_tx(d_q[i], 1'b0);
    for (int i = 14; i >= 0; i--) put_tx(crc_val[i], 1'b1);
    if (tx_run == int'(STUFF_LEN)) begin
      tx_bit.push_back(!tx_last); tx_cf.push_back(1'b1); tx_st.push_back(1'b1);
    end
    last_j = tx_bit.size() - 1;
    inj = -1; nst = 0;
    for (int j = 0; j <= last_j; j++) begin
      if (tx_st[j]) begin
        if (inject == -2 || inject == nst) inj = j;
        nst++;
      end
    end
    calc = crc_div(n);
    start_frame(ft_tick);
    nd = 0;
    for (int j = 0; j <= last_j; j++) begin
      if (j == last_j && tx_st[j]) idle(4);
      else idle(int'($urandom_range(0, 2)));
      if (j == inj) begin
        push_exp(K_STUFF, 1'b0, crc_div(nd), 15'h0, 1'b0);
        tick(!tx_bit[j], tx_cf[j]);
        idle(4);
        return;
      end
      if (!tx_st[j]) begin
        push_exp(K_DBIT, tx_bit[j], 15'h0, 15'h0, 1'b0);
        if (!tx_cf[j]) nd++;
      end
      if (j == last_j) push_exp(K_DONE, 1'b0, calc, crc_val, calc != crc_val);
      tick(tx_bit[j], tx_cf[j]);
    end
    idle(4);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (bus.dbit_valid) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_dbit: got dbit_valid expected none");
        end else begin
          e = exp_q.pop_front();
          chk("dbit_event", 32'(K_DBIT), 32'(e.kind));
          chk("dbit_value", 32'(bus.dbit), 32'(e.b));
        end
      end
      if (bus.stuff_err) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_stuff_err: got stuff_err expected none");
        end else begin
          e = exp_q.pop_front();
          chk("stuff_event", 32'(K_STUFF), 32'(e.kind));
          chk("stuff_crc_calc", 32'(bus.crc_calc), 32'(e.calc));
          chk("stuff_busy", 32'(bus.busy), 32'(0));
        end
      end
      if (bus.crc_done) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_crc_done: got crc_done expected none");
        end else begin
          e = exp_q.pop_front();
          chk("done_event", 32'(K_DONE), 32'(e.kind));
          chk("done_crc_calc", 32'(bus.crc_calc), 32'(e.calc));
          chk("done_crc_rcvd", 32'(bus.crc_rcvd), 32'(e.rcvd));
          chk("done_crc_err", 32'(bus.crc_err), 32'(e.err));
          chk("done_busy", 32'(bus.busy), 32'(0));
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : main
    bit prev;
    int n;
    logic [14:0] cv;
    rst = 1'b1;
    bus.bit_tick = 1'b0; bus.rx_bit = 1'b0; bus.frame_start = 1'b0; bus.crc_field = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_flags", 32'({bus.dbit_valid, bus.dbit, bus.stuff_err, bus.crc_done,
                            bus.crc_err, bus.busy}), 32'(0));
    chk("reset_crc_calc", 32'(bus.crc_calc), 32'(0));
    chk("reset_crc_rcvd", 32'(bus.crc_rcvd), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // good frame, then the same frame with the last CRC bit flipped
    d_q = '{0, 1, 0, 1, 1, 0, 1, 0};
    run_frame(15'h64FE, -1, 1'b0);
    chk("t1_crc_calc", 32'(bus.crc_calc), 32'h64FE);
    chk("t1_crc_rcvd", 32'(bus.crc_rcvd), 32'h64FE);
    chk("t1_crc_err", 32'(bus.crc_err), 32'(0));
    run_frame(15'h64FF, -1, 1'b0);
    idle(5);
    chk("t2_crc_rcvd", 32'(bus.crc_rcvd), 32'h64FF);
    chk("t2_crc_err_held", 32'(bus.crc_err), 32'(1));

    // six equal bits
    d_q = '{0, 0, 0, 0, 0, 0};
    run_frame(crc_div(6), 0, 1'b0);
    chk("t3_busy", 32'(bus.busy), 32'(0));

    // CRC field ending in five ones: trailing stuff consumed, then violated
    d_q = '{0, 1, 0, 1};
    run_frame(15'h0A1F, -1, 1'b0);
    run_frame(15'h0A1F, -2, 1'b0);

    // restart after four data bits
    d_q = '{0, 1, 0, 1, 1, 0, 1, 0};
    start_frame(1'b0);
    for (int i = 0; i < 4; i++) begin
      push_exp(K_DBIT, d_q[i], 15'h0, 15'h0, 1'b0);
      tick(d_q[i], 1'b0);
    end
    idle(2);
    start_frame(1'b0);
    @(negedge clk);
    chk("t5_crc_calc", 32'(bus.crc_calc), 32'(0));
    chk("t5_crc_rcvd", 32'(bus.crc_rcvd), 32'(0));
    chk("t5_busy", 32'(bus.busy), 32'(1));
    run_frame(15'h64FE, -1, 1'b0);
    chk("t5_rerun_crc_err", 32'(bus.crc_err), 32'(0));

    // tick coincident with frame_start is dropped
    run_frame(15'h64FE, -1, 1'b1);

    // reset in the middle of a frame
    start_frame(1'b0);
    for (int i = 0; i < 5; i++) begin
      push_exp(K_DBIT, d_q[i], 15'h0, 15'h0, 1'b0);
      tick(d_q[i], 1'b0);
    end
    idle(2);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t6_rst_flags", 32'({bus.dbit_valid, bus.dbit, bus.stuff_err, bus.crc_done,
                             bus.crc_err, bus.busy}), 32'(0));
    chk("t6_rst_crc_calc", 32'(bus.crc_calc), 32'(0));
    chk("t6_rst_crc_rcvd", 32'(bus.crc_rcvd), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // randomized frames
    for (int f = 0; f < 30; f++) begin
      n = int'($urandom_range(1, 20));
      d_q.delete();
      prev = 1'b0;
      d_q.push_back(1'b0);
      for (int i = 1; i < n; i++) begin
        prev = ($urandom_range(0, 99) < 65) ? prev : !prev;
        d_q.push_back(prev);
      end
      cv = ($urandom_range(0, 3) != 0) ? crc_div(n) : 15'($urandom);
      run_frame(cv, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1, 1'b0);
    end

    idle(10);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
